// File: rtl/csc_pkg.sv
// Shared types and helpers for the colour space converter output stage.
package csc_pkg;

    localparam int CSC_DATA_W = 8;
    localparam int AVG_W      = 16;

    typedef struct packed {
        logic [CSC_DATA_W-1:0] y;
        logic [CSC_DATA_W-1:0] c;
        logic                  sel;
    } csc_pix_t;

    typedef enum logic {
        CSC_444 = 1'b0,
        CSC_422 = 1'b1
    } csc_mode_e;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pair_phase_e;

    // Round-half-up mean; the result of two n-bit values always fits in n bits.
    function automatic logic [AVG_W-1:0] csc_avg(
        input logic [AVG_W-1:0] a,
        input logic [AVG_W-1:0] b
    );
        logic [AVG_W:0] s;
        s = {1'b0, a} + {1'b0, b} + 1'b1;
        return s[AVG_W:1];
    endfunction

endpackage

// File: rtl/csc_sync_fifo.sv
// First-word-fall-through FIFO with the head held in an output register.
module csc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 25,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [W-1:0]     data_o,
    output logic [LVL_W-1:0] level_o,
    output logic             pop_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] mem_cnt;
    logic             valid_q;
    logic [W-1:0]     data_q;
    logic             pop;
    logic             take;
    logic             acc;
    logic             bypass;
    logic             mem_wr;

    // Level counts the output register plus the array entries behind it.
    always_comb begin
        pop     = valid_q && ready_i;
        take    = !valid_q || pop;
        mem_cnt = level_q - LVL_W'(valid_q);
        acc     = wr_en_i && ((level_q != LVL_W'(DEPTH)) || pop);
        bypass  = take && (mem_cnt == '0);
        mem_wr  = acc && !bypass;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (take) begin
                if (mem_cnt != '0) begin
                    data_q   <= mem[rd_ptr_q];
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    valid_q  <= 1'b1;
                end else if (acc) begin
                    data_q  <= wr_data_i;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
            if (mem_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            level_q <= level_q + LVL_W'(acc) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign level_o = level_q;
    assign pop_o   = pop;
    assign drop_o  = wr_en_i && !acc;

endmodule

// File: rtl/csc_out_buffer.sv
// CSC output stage: optional 4:2:2 chroma averaging into a valid/ready FIFO.
// Define CSC_OUT_STATS_EN to add beat_cnt_o / drop_cnt_o statistics ports.
module csc_out_buffer
    import csc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              mode_422_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [DATA_W-1:0] cb_i,
    input  logic [DATA_W-1:0] cr_i,
    input  logic              ready_i,
    output logic              data_valid_o,
    output logic [DATA_W-1:0] y_o,
    output logic [DATA_W-1:0] cb_o,
    output logic [DATA_W-1:0] cr_o,
    output logic              chroma_sel_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              overflow_o
`ifdef CSC_OUT_STATS_EN
    ,
    output logic [31:0]       beat_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int EW = 3 * DATA_W + 1;

    csc_mode_e         mode_q;
    pair_phase_e       phase_q;
    pair_phase_e       phase_d;
    logic [DATA_W-1:0] y0_q;
    logic [DATA_W-1:0] cb0_q;
    logic [DATA_W-1:0] cr0_q;
    logic              pend_vld_q;
    logic              pend_vld_d;
    logic [EW-1:0]     pend_q;
    logic [EW-1:0]     pend_d;
    logic              hold_en;
    logic              is_422;
    logic [DATA_W-1:0] cb_avg;
    logic [DATA_W-1:0] cr_avg;
    logic              wr_en;
    logic [EW-1:0]     wr_data;
    logic [EW-1:0]     head;
    logic              pop;
    logic              drop;
    logic              overflow_q;

    assign is_422 = (mode_q == CSC_422);
    assign cb_avg = DATA_W'(csc_avg(AVG_W'(cb0_q), AVG_W'(cb_i)));
    assign cr_avg = DATA_W'(csc_avg(AVG_W'(cr0_q), AVG_W'(cr_i)));

    // A pending Cr beat always follows its Cb beat before the next EVEN
    // pixel can write, so the FIFO sees at most one write per cycle.
    always_comb begin
        phase_d    = phase_q;
        pend_vld_d = 1'b0;
        pend_d     = pend_q;
        hold_en    = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        if (pend_vld_q) begin
            wr_en   = 1'b1;
            wr_data = pend_q;
        end
        if (data_valid_i) begin
            if (!is_422) begin
                wr_en   = 1'b1;
                wr_data = {y_i, cb_i, cr_i, 1'b0};
            end else begin
                unique case (phase_q)
                    EVEN: begin
                        hold_en = 1'b1;
                        phase_d = ODD;
                    end
                    ODD: begin
                        wr_en      = 1'b1;
                        wr_data    = {y0_q, cb_avg, {DATA_W{1'b0}}, 1'b0};
                        pend_vld_d = 1'b1;
                        pend_d     = {y_i, cr_avg, {DATA_W{1'b0}}, 1'b1};
                        phase_d    = EVEN;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            mode_q     <= mode_422_i ? CSC_422 : CSC_444;
            phase_q    <= EVEN;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            y0_q       <= '0;
            cb0_q      <= '0;
            cr0_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if ((phase_q == EVEN) && !pend_vld_q) begin
                mode_q <= mode_422_i ? CSC_422 : CSC_444;
            end
            phase_q    <= phase_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            if (hold_en) begin
                y0_q  <= y_i;
                cb0_q <= cb_i;
                cr0_q <= cr_i;
            end
            overflow_q <= overflow_q | drop;
        end
    end

    csc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .ready_i   (ready_i),
        .valid_o   (data_valid_o),
        .data_o    (head),
        .level_o   (level_o),
        .pop_o     (pop),
        .drop_o    (drop)
    );

    assign y_o          = head[EW-1 -: DATA_W];
    assign cb_o         = head[EW-1-DATA_W -: DATA_W];
    assign cr_o         = head[DATA_W:1];
    assign chroma_sel_o = head[0];
    assign overflow_o   = overflow_q;

`ifdef CSC_OUT_STATS_EN
    logic [31:0] beat_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pop) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign beat_cnt_o = beat_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_csc_out_buffer.sv
// Scoreboard bench for csc_out_buffer with a pixel-level reference model.
module tb_csc_out_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       sel;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              mode_422_i = 1'b0;
    logic              data_valid_i = 1'b0;
    logic [DATA_W-1:0] y_i = '0;
    logic [DATA_W-1:0] cb_i = '0;
    logic [DATA_W-1:0] cr_i = '0;
    logic              ready_i = 1'b0;
    logic              data_valid_o;
    logic [DATA_W-1:0] y_o;
    logic [DATA_W-1:0] cb_o;
    logic [DATA_W-1:0] cr_o;
    logic              chroma_sel_o;
    logic [LVL_W-1:0]  level_o;
    logic              overflow_o;
`ifdef CSC_OUT_STATS_EN
    logic [31:0]       beat_cnt_o;
    logic [15:0]       drop_cnt_o;
`endif

    csc_out_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .mode_422_i   (mode_422_i),
        .data_valid_i (data_valid_i),
        .y_i          (y_i),
        .cb_i         (cb_i),
        .cr_i         (cr_i),
        .ready_i      (ready_i),
        .data_valid_o (data_valid_o),
        .y_o          (y_o),
        .cb_o         (cb_o),
        .cr_o         (cr_o),
        .chroma_sel_o (chroma_sel_o),
        .level_o      (level_o),
        .overflow_o   (overflow_o)
`ifdef CSC_OUT_STATS_EN
        ,
        .beat_cnt_o   (beat_cnt_o),
        .drop_cnt_o   (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    logic  m422 = 1'b0;
    logic  half = 1'b0;
    logic [7:0] hy, hcb, hcr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected beats on transfer and checks stall stability.
    beat_t prev;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {data_valid_o, y_o, cb_o, cr_o, chroma_sel_o},
                    {1'b1, prev});
            if (data_valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t",
                             {y_o, cb_o, cr_o, chroma_sel_o}, $time);
                end else begin
                    chk("beat", {y_o, cb_o, cr_o, chroma_sel_o}, exp_q.pop_front());
                end
            end
            prev_stall = data_valid_o && !ready_i;
            prev = {y_o, cb_o, cr_o, chroma_sel_o};
        end
    end

    function automatic logic [7:0] mavg(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return s[7:0];
    endfunction

    task automatic model_pix(input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr);
        beat_t b;
        if (!m422) begin
            b = {y, cb, cr, 1'b0};
            if (exp_q.size() < DEPTH || ready_i) exp_q.push_back(b);
        end else if (!half) begin
            hy = y; hcb = cb; hcr = cr;
            half = 1'b1;
        end else begin
            b = {hy, mavg(hcb, cb), 8'h00, 1'b0};
            exp_q.push_back(b);
            b = {y, mavg(hcr, cr), 8'h00, 1'b1};
            exp_q.push_back(b);
            half = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] y, input logic [7:0] cb,
                        input logic [7:0] cr);
        y_i = y; cb_i = cb; cr_i = cr;
        data_valid_i = 1'b1;
        model_pix(y, cb, cr);
        cyc();
        data_valid_i = 1'b0;
    endtask

    task automatic send_rand();
        send(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic reset_dut(input logic m);
        rst_i = 1'b1;
        data_valid_i = 1'b0;
        mode_422_i = m;
        exp_q.delete();
        half = 1'b0;
        m422 = m;
        cyc();
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {data_valid_o, y_o, cb_o, cr_o, chroma_sel_o, overflow_o},
            '0);
        chk("reset_level", 32'(level_o), 0);
        cyc();
    endtask

    task automatic drain();
        ready_i = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc();
        chk("drain_left", exp_q.size(), 0);
        repeat (2) cyc();
        @(negedge clk);
        chk("drained_valid", 32'(data_valid_o), 0);
        chk("drained_level", 32'(level_o), 0);
        cyc();
    endtask

    task automatic set_mode(input logic m);
        if (half) begin
            drain();
            send_rand();
        end
        mode_422_i = m;
        repeat (3) cyc();
        m422 = m;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 4:4:4 single pixel, one-cycle latency
        reset_dut(1'b0);
        ready_i = 1'b1;
        send(8'h10, 8'h80, 8'h90);
        @(negedge clk);
        chk("444_latency_valid", 32'(data_valid_o), 1);
        chk("444_pixel", {y_o, cb_o, cr_o, chroma_sel_o}, {8'h10, 8'h80, 8'h90, 1'b0});
        cyc();
        drain();

        // 4:2:2 pair
        set_mode(1'b1);
        send(8'h20, 8'h10, 8'hF0);
        send(8'h21, 8'h13, 8'hF3);
        @(negedge clk);
        chk("422_beat0", {data_valid_o, y_o, cb_o, cr_o, chroma_sel_o},
            {1'b1, 8'h20, 8'h12, 8'h00, 1'b0});
        @(negedge clk);
        chk("422_beat1", {data_valid_o, y_o, cb_o, cr_o, chroma_sel_o},
            {1'b1, 8'h21, 8'hF2, 8'h00, 1'b1});
        cyc();
        drain();

        // Overflow: DEPTH+2 pixels with no reads
        reset_dut(1'b0);
        ready_i = 1'b0;
        repeat (DEPTH + 2) send_rand();
        @(negedge clk);
        chk("ovf_level", 32'(level_o), DEPTH);
        chk("ovf_flag", 32'(overflow_o), 1);
        cyc();
        drain();
        chk("ovf_sticky", 32'(overflow_o), 1);
`ifdef CSC_OUT_STATS_EN
        chk("stats_beats", beat_cnt_o, DEPTH);
        chk("stats_drops", 32'(drop_cnt_o), 2);
`endif

        // Full FIFO with simultaneous read and write
        reset_dut(1'b0);
        ready_i = 1'b0;
        repeat (DEPTH) send_rand();
        @(negedge clk);
        chk("full_level", 32'(level_o), DEPTH);
        chk("full_no_ovf", 32'(overflow_o), 0);
        cyc();
        ready_i = 1'b1;
        send_rand();
        ready_i = 1'b0;
        @(negedge clk);
        chk("rw_full_level", 32'(level_o), DEPTH);
        chk("rw_full_no_ovf", 32'(overflow_o), 0);
        cyc();
        drain();

        // Mode toggle while ODD: pair completes as 4:2:2
        reset_dut(1'b1);
        ready_i = 1'b1;
        send(8'h40, 8'h20, 8'h60);
        mode_422_i = 1'b0;
        send(8'h41, 8'h23, 8'h63);
        repeat (3) cyc();
        m422 = 1'b0;
        send(8'h55, 8'h66, 8'h77);
        drain();

        // Reset mid-pair with beats buffered and pending
        reset_dut(1'b1);
        ready_i = 1'b0;
        repeat (3) send_rand();
        reset_dut(1'b1);
        ready_i = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        chk("no_stale_beat", 32'(data_valid_o), 0);
        cyc();
        send(8'h01, 8'h02, 8'h03);
        send(8'h04, 8'h05, 8'h06);
        drain();

        // Randomised traffic in both modes with random backpressure
        for (int seg = 0; seg < 6; seg++) begin
            set_mode(seg[0]);
            for (int i = 0; i < 300; i++) begin
                ready_i = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) != 0 && exp_q.size() <= DEPTH - 4)
                    send_rand();
                else
                    cyc();
            end
        end
        if (half) begin
            drain();
            send_rand();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
